// File: rtl/timebase_ctrl_pkg.sv
// Shared oscilloscope definitions: capture FSM states, timebase limits and
// the clock-cycles-per-sample divider table indexed by scale.
package timebase_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } tb_state_t;

    localparam logic [4:0] SCALE_MAX = 5'd19;
    localparam int         DIV_W     = 17;

    // Indices past SCALE_MAX map to 1 so the divider never sees 0
    function automatic logic [DIV_W-1:0] div_of(input logic [4:0] idx);
        case (idx)
            5'd5:    div_of = 17'd2;
            5'd6:    div_of = 17'd4;
            5'd7:    div_of = 17'd10;
            5'd8:    div_of = 17'd20;
            5'd9:    div_of = 17'd40;
            5'd10:   div_of = 17'd100;
            5'd11:   div_of = 17'd200;
            5'd12:   div_of = 17'd400;
            5'd13:   div_of = 17'd1000;
            5'd14:   div_of = 17'd2000;
            5'd15:   div_of = 17'd4000;
            5'd16:   div_of = 17'd10000;
            5'd17:   div_of = 17'd20000;
            5'd18:   div_of = 17'd40000;
            5'd19:   div_of = 17'd100000;
            default: div_of = 17'd1;
        endcase
    endfunction

endpackage

// File: rtl/timebase_ctrl_sample_divider.sv
// Sample-rate divider: counts 0..div-1 and strobes sample_en on the last count.
module sample_divider
    import timebase_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [DIV_W-1:0] div,
    output logic             sample_en
);

    logic [DIV_W-1:0] cnt_r;
    logic             last_s;

    assign last_s    = (cnt_r >= (div - 17'd1));
    assign sample_en = (cnt_r == (div - 17'd1));

    // Divider counter; >= on wrap keeps it bounded if div ever shrinks
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= 17'd0;
        end else if (clr || last_s) begin
            cnt_r <= 17'd0;
        end else begin
            cnt_r <= cnt_r + 17'd1;
        end
    end

endmodule

// File: rtl/timebase_ctrl.sv
// Oscilloscope timebase and capture controller: scale selection, sample strobe
// generation and the IDLE/ARMED/CAPTURE/DONE write sequencer.
module timebase_ctrl
    import timebase_ctrl_pkg::*;
#(
    parameter int DEPTH   = 1024,
    parameter int ADDR_W  = 10,
    parameter int RST_IDX = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              scale_up,
    input  logic              scale_down,
    input  logic              arm,
    input  logic              abort,
    input  logic              trig,
    output logic [4:0]        scale_idx,
    output logic              sample_en,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              busy,
    output logic              done
);

    tb_state_t        state_r;
    tb_state_t        state_next_s;
    logic [ADDR_W-1:0] addr_next_s;
    logic [4:0]       idx_next_s;
    logic             scale_ok_s;
    logic             arm_go_s;
    logic             div_clr_s;
    logic [DIV_W-1:0] div_s;

    assign scale_ok_s = (state_r == ST_IDLE) || (state_r == ST_DONE);
    assign arm_go_s   = arm && !abort && scale_ok_s;
    assign div_clr_s  = (idx_next_s != scale_idx) || arm_go_s;
    assign div_s      = div_of(scale_idx);

    assign wr_en = (state_r == ST_CAPTURE) && sample_en;
    assign busy  = (state_r == ST_ARMED) || (state_r == ST_CAPTURE);
    assign done  = (state_r == ST_DONE);

    sample_divider u_sample_divider (
        .clk       (clk),
        .rst       (rst),
        .clr       (div_clr_s),
        .div       (div_s),
        .sample_en (sample_en)
    );

    // Next scale index; opposing requests in the same cycle cancel
    always_comb begin
        idx_next_s = scale_idx;
        if (scale_ok_s && scale_up && !scale_down && (scale_idx < SCALE_MAX)) begin
            idx_next_s = scale_idx + 5'd1;
        end else if (scale_ok_s && scale_down && !scale_up && (scale_idx != 5'd0)) begin
            idx_next_s = scale_idx - 5'd1;
        end else begin
            idx_next_s = scale_idx;
        end
    end

    // Capture sequencer next state; abort overrides everything else
    always_comb begin
        state_next_s = state_r;
        addr_next_s  = wr_addr;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (arm) begin
                    state_next_s = ST_ARMED;
                end else begin
                    state_next_s = state_r;
                end
            end
            ST_ARMED: begin
                if (trig) begin
                    state_next_s = ST_CAPTURE;
                    addr_next_s  = {ADDR_W{1'b0}};
                end else begin
                    state_next_s = ST_ARMED;
                end
            end
            ST_CAPTURE: begin
                if (wr_en && (wr_addr == ADDR_W'(DEPTH - 1))) begin
                    state_next_s = ST_DONE;
                    addr_next_s  = {ADDR_W{1'b0}};
                end else if (wr_en) begin
                    addr_next_s = wr_addr + ADDR_W'(1);
                end else begin
                    addr_next_s = wr_addr;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                addr_next_s  = {ADDR_W{1'b0}};
            end
        endcase
        if (abort) begin
            state_next_s = ST_IDLE;
            addr_next_s  = {ADDR_W{1'b0}};
        end else begin
            addr_next_s = addr_next_s;
        end
    end

    // State, address and scale registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            wr_addr   <= {ADDR_W{1'b0}};
            scale_idx <= 5'(RST_IDX);
        end else begin
            state_r   <= state_next_s;
            wr_addr   <= addr_next_s;
            scale_idx <= idx_next_s;
        end
    end

endmodule

// File: tb/tb_timebase_ctrl.sv
// Self-checking bench for timebase_ctrl: scale stepping, sample rates, full
// capture with a write-address scoreboard, abort and mid-capture reset.
module tb_timebase_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       scale_up = 1'b0;
    logic       scale_down = 1'b0;
    logic       arm = 1'b0;
    logic       abort = 1'b0;
    logic       trig = 1'b0;
    logic [4:0] scale_idx;
    logic       sample_en;
    logic       wr_en;
    logic [9:0] wr_addr;
    logic       busy;
    logic       done;

    int         n_checks = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         n_wr = 0;
    int         last_wr = -1;
    int         exp_gap = 0;
    logic [9:0] exp_q[$];
    logic [9:0] mon_exp;
    int         model_idx;

    timebase_ctrl #(.DEPTH(1024), .ADDR_W(10), .RST_IDX(14)) dut (
        .clk        (clk),
        .rst        (rst),
        .scale_up   (scale_up),
        .scale_down (scale_down),
        .arm        (arm),
        .abort      (abort),
        .trig       (trig),
        .scale_idx  (scale_idx),
        .sample_en  (sample_en),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Write monitor: pops the expected address for every wr_en and checks spacing
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL wr_unexpected: wr_en=1 at wr_addr=%0d, required no write", wr_addr);
            end else begin
                mon_exp = exp_q.pop_front();
                if (wr_addr !== mon_exp) begin
                    n_fail++;
                    $display("FAIL wr_addr: got %0d, expected %0d", wr_addr, mon_exp);
                end
            end
            if (exp_gap != 0 && last_wr >= 0) begin
                n_checks++;
                if (cyc - last_wr != exp_gap) begin
                    n_fail++;
                    $display("FAIL wr_gap: got %0d clocks, expected %0d", cyc - last_wr, exp_gap);
                end
            end
            last_wr = cyc;
            n_wr++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_up();
        scale_up = 1'b1; tick(); scale_up = 1'b0;
    endtask

    task automatic pulse_down();
        scale_down = 1'b1; tick(); scale_down = 1'b0;
    endtask

    task automatic start_capture();
        arm = 1'b1; tick(); arm = 1'b0;
        tick(); tick();
        trig = 1'b1;
        for (int a = 0; a < 1024; a++) exp_q.push_back(10'(a));
        last_wr = -1;
        n_wr = 0;
        exp_gap = 2;
        tick();
        trig = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        tick(); tick();
        n_checks++;
        if (scale_idx !== 5'd14 || busy !== 1'b0 || done !== 1'b0 || wr_en !== 1'b0 || wr_addr !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_state: idx=%0d busy=%b done=%b wr_en=%b addr=%0d, expected 14 0 0 0 0",
                     scale_idx, busy, done, wr_en, wr_addr);
        end
        rst = 1'b0;
        tick();
        n_checks++;
        if (scale_idx !== 5'd14 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: idx=%0d busy=%b, expected 14 0", scale_idx, busy);
        end
        model_idx = 14;
    endtask

    task automatic test_scale_steps();
        for (int i = 0; i < 6; i++) begin
            pulse_up();
            model_idx = (model_idx < 19) ? model_idx + 1 : 19;
            n_checks++;
            if (scale_idx !== 5'(model_idx)) begin
                n_fail++;
                $display("FAIL scale_up_%0d: got %0d, expected %0d", i, scale_idx, model_idx);
            end
        end
        scale_up = 1'b1; scale_down = 1'b1; tick(); scale_up = 1'b0; scale_down = 1'b0;
        n_checks++;
        if (scale_idx !== 5'd19) begin
            n_fail++;
            $display("FAIL scale_both: got %0d, expected 19", scale_idx);
        end
        for (int i = 0; i < 12; i++) begin
            pulse_down();
            model_idx = (model_idx > 0) ? model_idx - 1 : 0;
            n_checks++;
            if (scale_idx !== 5'(model_idx)) begin
                n_fail++;
                $display("FAIL scale_down_%0d: got %0d, expected %0d", i, scale_idx, model_idx);
            end
        end
    endtask

    task automatic test_rate_idx7();
        int t;
        t = 0;
        while (sample_en !== 1'b1 && t < 40) begin tick(); t++; end
        for (int k = 0; k < 2; k++) begin
            t = 0;
            do begin tick(); t++; end while (sample_en !== 1'b1 && t < 40);
            n_checks++;
            if (t != 10) begin
                n_fail++;
                $display("FAIL rate_idx7_%0d: period %0d clocks, expected 10", k, t);
            end
        end
    endtask

    task automatic test_rate_fast();
        int highs;
        pulse_down(); pulse_down();
        for (int idx = 4; idx >= 0; idx--) begin
            pulse_down();
            highs = 0;
            for (int c = 0; c < 5; c++) begin
                if (sample_en === 1'b1) highs++;
                tick();
            end
            n_checks++;
            if (scale_idx !== 5'(idx) || highs != 5) begin
                n_fail++;
                $display("FAIL rate_fast_%0d: idx=%0d strobes=%0d/5, expected idx %0d strobes 5", idx, scale_idx, highs, idx);
            end
        end
        pulse_down();
        n_checks++;
        if (scale_idx !== 5'd0) begin
            n_fail++;
            $display("FAIL scale_floor: got %0d, expected 0", scale_idx);
        end
    endtask

    task automatic test_capture();
        int t;
        for (int i = 0; i < 5; i++) pulse_up();
        trig = 1'b1; tick(); trig = 1'b0;
        n_checks++;
        if (scale_idx !== 5'd5 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL trig_in_idle: idx=%0d busy=%b, expected 5 0", scale_idx, busy);
        end
        start_capture();
        n_checks++;
        if (busy !== 1'b1 || wr_addr !== 10'd0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL capture_start: busy=%b addr=%0d done=%b, expected 1 0 0", busy, wr_addr, done);
        end
        t = 0;
        while (done !== 1'b1 && t < 3000) begin
            arm = (t == 100);
            tick();
            t++;
        end
        arm = 1'b0;
        exp_gap = 0;
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0 || wr_addr !== 10'd0) begin
            n_fail++;
            $display("FAIL capture_done: done=%b busy=%b addr=%0d, expected 1 0 0", done, busy, wr_addr);
        end
        n_checks++;
        if (n_wr != 1024 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL capture_count: writes=%0d left=%0d, expected 1024 0", n_wr, exp_q.size());
        end
    endtask

    task automatic test_abort_arm_done();
        abort = 1'b1; arm = 1'b1; tick(); abort = 1'b0; arm = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || wr_addr !== 10'd0) begin
            n_fail++;
            $display("FAIL abort_arm: busy=%b done=%b addr=%0d, expected 0 0 0", busy, done, wr_addr);
        end
    endtask

    task automatic test_scale_in_capture();
        start_capture();
        for (int t = 0; t < 200; t++) begin
            scale_up = (t == 50);
            tick();
        end
        scale_up = 1'b0;
        n_checks++;
        if (scale_idx !== 5'd5 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL scale_in_capture: idx=%0d busy=%b, expected 5 1", scale_idx, busy);
        end
        abort = 1'b1; tick(); abort = 1'b0;
        exp_q.delete();
        exp_gap = 0;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || wr_addr !== 10'd0) begin
            n_fail++;
            $display("FAIL abort_capture: busy=%b done=%b addr=%0d, expected 0 0 0", busy, done, wr_addr);
        end
        for (int t = 0; t < 6; t++) tick();
    endtask

    task automatic test_reset_mid();
        int t;
        start_capture();
        t = 0;
        while (wr_addr !== 10'd500 && t < 2000) begin tick(); t++; end
        n_checks++;
        if (wr_addr !== 10'd500) begin
            n_fail++;
            $display("FAIL reach_500: addr=%0d, expected 500", wr_addr);
        end
        rst = 1'b1;
        exp_q.delete();
        exp_gap = 0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || wr_en !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_async: busy=%b wr_en=%b done=%b, expected 0 0 0", busy, wr_en, done);
        end
        tick(); tick();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        n_checks++;
        if (wr_addr !== 10'd0 || scale_idx !== 5'd14 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_after: addr=%0d idx=%0d busy=%b, expected 0 14 0", wr_addr, scale_idx, busy);
        end
    endtask

    initial begin
        test_reset();
        test_scale_steps();
        test_rate_idx7();
        test_rate_fast();
        test_capture();
        test_abort_arm_done();
        test_scale_in_capture();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/timebase_ctrl.md
TIMEBASE_CTRL -- requirements
Module: timebase_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, capture length in samples (power of two).
REQ-002 SHALL have parameter ADDR_W, default 10, equal to log2(DEPTH).
REQ-003 SHALL have parameter RST_IDX, default 14, scale index loaded at reset.
REQ-004 SHALL have port clk, input, 1, the single clock for all logic.
REQ-005 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-006 SHALL have port scale_up, input, 1, one-cycle pulse requesting the next slower scale.
REQ-007 SHALL have port scale_down, input, 1, one-cycle pulse requesting the next faster scale.
REQ-008 SHALL have port arm, input, 1, one-cycle pulse starting a capture sequence.
REQ-009 SHALL have port abort, input, 1, one-cycle pulse returning the block to IDLE.
REQ-010 SHALL have port trig, input, 1, one-cycle trigger event from the trigger comparator.
REQ-011 SHALL have port scale_idx, output, 5, current timebase index, range 0..19.
REQ-012 SHALL have port sample_en, output, 1, sample strobe at the rate selected by the current scale.
REQ-013 SHALL have port wr_en, output, 1, capture-memory write enable.
REQ-014 SHALL have port wr_addr, output, ADDR_W, capture-memory write address.
REQ-015 SHALL have port busy, output, 1, high in ARMED or CAPTURE.
REQ-016 SHALL have port done, output, 1, high in DONE.

Function
REQ-017 SHALL implement states IDLE, ARMED, CAPTURE and DONE, all registered.
REQ-018 SHALL accept scale changes only in IDLE or DONE, and SHALL ignore them in ARMED and CAPTURE.
REQ-019 SHALL apply scale_up as idx+1, saturating at 19, and scale_down as idx-1, saturating at 0.
REQ-020 SHALL leave the index unchanged when scale_up and scale_down are asserted in the same cycle.
REQ-021 SHALL take the divider DIV[idx] (clock cycles per sample, 17 bits, minimum 1) from the package table.
- Table values for idx 0..19: 1,1,1,1,1,2,4,10,20,40,100,200,400,1000,2000,4000,10000,20000,40000,100000.
REQ-022 SHALL count the divider 0..DIV-1 and wrap, asserting sample_en for the cycle in which the count equals DIV-1.
- With DIV=1, sample_en is high every cycle.
REQ-023 SHALL clear the divider counter to 0 on the cycle after a scale change and on entry to ARMED.
REQ-024 SHALL move from IDLE or DONE to ARMED on arm, and SHALL clear done on the next cycle.
REQ-025 SHALL ignore arm in ARMED and CAPTURE.
REQ-026 SHALL move from ARMED to CAPTURE in the cycle after trig is sampled high, with wr_addr=0.
REQ-027 SHALL ignore trig in all states other than ARMED.
REQ-028 SHALL drive wr_en equal to (state==CAPTURE && sample_en), combinationally from registered signals.
REQ-029 SHALL hold wr_addr on each wr_en cycle and increment it on the following cycle.
REQ-030 SHALL, on the wr_en cycle with wr_addr==DEPTH-1, enter DONE on the next cycle with wr_addr wrapped to 0.
- This gives exactly DEPTH writes per capture.
REQ-031 SHALL force IDLE on the next cycle when abort is high in any state, and SHALL clear wr_addr to 0.
REQ-032 SHALL give abort priority over arm, trig and capture completion when they coincide.

Reset
REQ-033 SHALL, on rst, asynchronously set state=IDLE, scale_idx=RST_IDX, divider count=0, wr_addr=0.
REQ-034 SHALL hold busy, done and wr_en at 0 while rst is asserted.
REQ-035 SHALL discard a partial capture when rst is asserted mid-capture, with no further wr_en pulses.

Structure
REQ-036 SHALL place the state enum, SCALE_MAX=19 and the DIV table in the shared oscilloscope package.
REQ-037 SHALL contain one sub-module, sample_divider, holding the divider counter and generating sample_en.

Verification
REQ-038 SHALL show that scale_up pulsed 6 times from reset gives scale_idx 15,16,17,18,19,19.
REQ-039 SHALL show that at idx=7, sample_en pulses every 10 clocks, and at idx 0..4 on every clock.
REQ-040 SHALL show that idx=5, arm, then trig after 3 cycles gives 1024 wr_en pulses 2 clocks apart, wr_addr 0..1023, then done=1.
REQ-041 SHALL show that scale_up during CAPTURE leaves scale_idx and the sample_en period unchanged.
REQ-042 SHALL show that abort together with arm in DONE gives state IDLE and done=0 on the next cycle.
REQ-043 SHALL show that rst asserted at wr_addr=500 immediately gives busy=0 and wr_en=0, and that wr_addr=0 and scale_idx=14 are held after release.
